// File: rtl/bp_profiler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_profiler_pkg
//  Brief    : Shared types, address map and helpers for the stall profiler.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_profiler_pkg;

  localparam int stall_reason_width_lp = 5;

  // Named stall reasons; index 0 is the catch-all "unknown" bucket.
  typedef enum logic [stall_reason_width_lp-1:0] {
    e_unknown           = 5'd0,
    e_icache_miss       = 5'd1,
    e_itlb_miss         = 5'd2,
    e_branch_mispredict = 5'd3,
    e_dcache_miss       = 5'd4,
    e_dtlb_miss         = 5'd5,
    e_fe_queue_empty    = 5'd6,
    e_struct_hazard     = 5'd7,
    e_data_hazard       = 5'd8,
    e_long_latency      = 5'd9,
    e_exception         = 5'd10,
    e_interrupt         = 5'd11
  } bp_stall_reason_e;

  // Clog2 that never returns 0, so derived widths stay legal.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Read address map: reason counters 0..n-1, then cycles, then instret.
  function automatic int cycle_addr(input int n);
    return n;
  endfunction

  function automatic int instret_addr(input int n);
    return n + 1;
  endfunction

  localparam int default_num_reasons_lp = 24;
  localparam int cycle_addr_lp          = cycle_addr(default_num_reasons_lp);
  localparam int instret_addr_lp        = instret_addr(default_num_reasons_lp);

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bp_sat_counter
//  Brief    : Saturating up-counter with synchronous clear. sat_o flags an
//             increment that was blocked because the counter is full.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o,
  output logic               sat_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               w_full;

  assign w_full  = &count_q;
  assign sat_o   = inc_i & w_full;
  assign count_o = count_q;

  // Next count: clear dominates, otherwise increment unless already full.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !w_full) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule
`default_nettype wire

// File: rtl/bp_stall_histogram.sv
`default_nettype none
// ============================================================================
//  Module   : bp_stall_histogram
//  Brief    : Per-core stall-attribution profiler. Delays the stall-reason
//             vector to commit, resolves one reason per non-retiring cycle,
//             keeps saturating histograms with optional windowed snapshots.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_stall_histogram
  import bp_profiler_pkg::*;
#(
  parameter  int num_reasons_p = 24,
  parameter  int cnt_width_p   = 32,
  parameter  int delay_p       = 8,
  parameter  int window_p      = 0,
  localparam int addr_width_lp = safe_clog2(num_reasons_p + 2)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     freeze_i,
  input  logic                     clear_i,
  input  logic [num_reasons_p-1:0] reason_i,
  input  logic                     instret_i,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_v_o,
  output logic [cnt_width_p-1:0]   rd_data_o,
  output logic                     window_done_o,
  output logic                     sat_o
);

  localparam int n_cnt_lp     = num_reasons_p + 2;
  localparam int cyc_idx_lp   = cycle_addr(num_reasons_p);
  localparam int ret_idx_lp   = instret_addr(num_reasons_p);
  localparam int sel_width_lp = safe_clog2(num_reasons_p);

  logic [num_reasons_p-1:0] dly_q [delay_p];
  logic [num_reasons_p-1:0] w_dly;
  logic [sel_width_lp-1:0]  w_sel;
  logic                     w_count_en;
  logic                     w_win_end;
  logic [n_cnt_lp-1:0]      w_inc;
  logic [n_cnt_lp-1:0]      w_blk;
  logic [cnt_width_p-1:0]   w_cnt [n_cnt_lp];
  logic [cnt_width_p-1:0]   w_src [n_cnt_lp];
  logic [cnt_width_p-1:0]   rd_data_d;
  logic                     rd_v_q;
  logic [cnt_width_p-1:0]   rd_data_q;
  logic                     sat_q;

  // Delay line aligning reason_i with commit; keeps shifting under freeze.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < delay_p; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= reason_i;
      for (int i = 1; i < delay_p; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign w_dly      = dly_q[delay_p-1];
  assign w_count_en = ~freeze_i & ~clear_i;

  // Lowest set reason above "unknown" wins; nothing set falls back to 0.
  always_comb begin
    w_sel = '0;
    for (int i = num_reasons_p - 1; i >= 0; i--) begin
      if (w_dly[i] && (i != 0)) w_sel = sel_width_lp'(i);
    end
  end

  // One-hot increment requests: cycle always, then instret or one reason.
  always_comb begin
    w_inc = '0;
    if (w_count_en) begin
      w_inc[cyc_idx_lp] = 1'b1;
      if (instret_i) w_inc[ret_idx_lp] = 1'b1;
      else           w_inc[w_sel]      = 1'b1;
    end
  end

  for (genvar g = 0; g < n_cnt_lp; g++) begin : g_cnt
    bp_sat_counter #(.width_p(cnt_width_p)) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_i     (clear_i | w_win_end),
      .inc_i     (w_inc[g]),
      .count_o   (w_cnt[g]),
      .sat_o     (w_blk[g])
    );
  end

  if (window_p == 0) begin : g_cum
    assign w_win_end     = 1'b0;
    assign window_done_o = 1'b0;

    // Cumulative mode reads the live counters directly.
    always_comb begin
      for (int i = 0; i < n_cnt_lp; i++) w_src[i] = w_cnt[i];
    end
  end else begin : g_win
    localparam int tmr_width_lp = safe_clog2(window_p);

    logic [tmr_width_lp-1:0] tmr_q, tmr_d;
    logic [cnt_width_p-1:0]  shadow_q [n_cnt_lp];
    logic                    done_q;

    assign w_win_end     = w_count_en && (tmr_q == tmr_width_lp'(window_p - 1));
    assign window_done_o = done_q;

    // Window timer advances only on counted cycles and wraps at window end.
    always_comb begin
      tmr_d = tmr_q;
      if (clear_i || w_win_end) tmr_d = '0;
      else if (w_count_en)      tmr_d = tmr_q + 1'b1;
    end

    // Timer and publish pulse registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        tmr_q  <= '0;
        done_q <= 1'b0;
      end else begin
        tmr_q  <= tmr_d;
        done_q <= w_win_end;
      end
    end

    // Shadow bank captures the counters including the final cycle's update.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        for (int i = 0; i < n_cnt_lp; i++) shadow_q[i] <= '0;
      end else if (clear_i) begin
        for (int i = 0; i < n_cnt_lp; i++) shadow_q[i] <= '0;
      end else if (w_win_end) begin
        for (int i = 0; i < n_cnt_lp; i++)
          shadow_q[i] <= w_cnt[i] + cnt_width_p'(w_inc[i] & ~(&w_cnt[i]));
      end
    end

    // Windowed mode reads the published snapshot.
    always_comb begin
      for (int i = 0; i < n_cnt_lp; i++) w_src[i] = shadow_q[i];
    end
  end

  // Read mux; addresses past the instret counter read as zero.
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr_i) < n_cnt_lp) rd_data_d = w_src[rd_addr_i];
  end

  // Registered read port and sticky saturation flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      rd_v_q    <= rd_v_i;
      rd_data_q <= rd_v_i ? rd_data_d : '0;
      sat_q     <= clear_i ? 1'b0 : (sat_q | (|w_blk));
    end
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;
  assign sat_o     = sat_q;

endmodule
`default_nettype wire
